fp_mult_result_collector: RTL and testbench
===========================================

# fp_mult_result_collector

Downstream companion of the pipelined single-precision multiplier `fp_mult_top`. The multiplier has a fixed latency and cannot stall, so this block gives it a credit-based input (`in_ready`) and a valid/ready output. It tracks in-flight operations with a valid shift register and captures each `z`/`status` pair into a FIFO when it emerges. It also keeps sticky IEEE exception flags and a result counter for software/bench readout.

## Interface

**Parameters**
- `LATENCY`, default 2: cycles from operand issue to `z`/`status` valid at the multiplier output; legal range 1..8.
- `DEPTH`, default 8: FIFO entries; power of two, 2..64.

**Ports**
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  high in the same cycle `a`/`b`/`rnd` are presented to the multiplier.
- `in_ready`  out  1  an issue in this cycle is guaranteed a FIFO slot.
- `z`  in  32  multiplier result.
- `status`  in  8  multiplier status byte:
  - bit0 zero, bit1 inf, bit2 invalid, bit3 tiny, bit4 huge, bit5 inexact;
  - bits 7:6 are ignored.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts the head.
- `out_z`  out  32  head result.
- `out_status`  out  8  head status, stored as received.
- `clear_sticky`  in  1  clears sticky flags.
- `sticky`  out  7  bits 5:0 are the OR of `status[5:0]` of captured results; bit 6 is overflow (a result was dropped).
- `result_count`  out  16  number of results captured into the FIFO; wraps modulo 2^16.

## Operation

**In-flight tracking**
- `vld_pipe[LATENCY-1:0]` shifts `in_valid` every cycle.
- `arrive = vld_pipe[LATENCY-1]`, so an issue in cycle t produces `arrive` in cycle t+LATENCY, when `z`/`status` are valid.
- `inflight` is the popcount of `vld_pipe`, maintained as an up/down counter.

**Credit**
- `in_ready = (occupancy + inflight) < DEPTH`.
- Combinational from registers only; no dependence on `in_valid` or `out_ready` in the same cycle.

**Issue while `in_ready`=0**
- The multiplier cannot be blocked, so the op still enters `vld_pipe`.
- On arrival, if the FIFO is full after this cycle's pop, the result is dropped and `sticky[6]` is set.
- A dropped result does not increment `result_count` and does not update `sticky[5:0]`.

**Capture (`arrive`=1, not dropped)**
- Write `{z, status}` at the tail.
- `sticky[5:0] |= status[5:0]`.
- `result_count += 1`.

**Pop**
- Occurs when `out_valid && out_ready`; the head advances.

**FIFO**
- Registered storage with head/tail pointers of width log2(DEPTH) that wrap naturally.
- `occupancy` is 0..DEPTH.
- `out_valid = occupancy != 0`.
- `out_z`/`out_status` come straight from `mem[head]`.

**Simultaneous events**
- Push and pop in the same cycle at full: both occur, occupancy stays DEPTH, no drop.
- Push and pop at empty is impossible, because a push is not visible on `out_*` until the next cycle (no fall-through).
- `clear_sticky` together with a capture: clear first, then OR the new flags, so the new result's flags remain set. `sticky[6]` is likewise cleared-then-set on a simultaneous drop.

## Timing

**Reset values** (synchronous `rst`=1 at an edge):
- `vld_pipe`=0, `inflight`=0, `occupancy`=0, pointers=0.
- `sticky`=0, `result_count`=0.
- Resulting outputs: `out_valid`=0, `in_ready`=1. `out_z`/`out_status` are don't-care while `out_valid`=0.

**Reset mid-operation**
- All in-flight tags and FIFO contents are discarded.
- Multiplier outputs emerging in the LATENCY cycles after reset deassertion are ignored, because `vld_pipe` is 0.

**Latency**
- An issue in cycle t is written at the edge ending cycle t+LATENCY.
- `out_valid` rises in cycle t+LATENCY+1 if the FIFO was empty. With LATENCY=2, the result is visible 3 cycles after issue.

**Throughput**
- One issue per cycle sustained while `out_ready`=1 continuously.
- `in_ready` never deasserts in that case, since steady-state occupancy+inflight ≤ LATENCY+1.

**Register timing of `in_ready`**
- It reflects state at the start of the cycle.
- An issue in cycle t counts against credit from cycle t+1.

**Ordering**
- Results leave in issue order; there is no reordering and no duplication.

## Test plan

- **Single op:** reset, issue a=0x3F800000, b=0x40000000 (rnd=0) at t=0, mult z=0x40000000, status=0x00 at t=2 → `out_valid`=1 at t=3, `out_z`=0x40000000, `result_count`=1, `sticky`=0.
- **Fill:** `out_ready`=0, issue every cycle while `in_ready` → exactly 8 issues accepted; `in_ready`=0 from the cycle after the 8th issue; then `out_ready`=1 drains 8 results in issue order, and `in_ready` returns to 1 after the first pop.
- **Overflow:** FIFO full with `out_ready`=0, force `in_valid`=1 for one cycle → at arrival `sticky[6]`=1, occupancy stays 8, `result_count` unchanged.
- **Full push+pop:** FIFO full with `out_ready`=1 in the arrival cycle → no drop, occupancy stays 8, `sticky[6]`=0.
- **Sticky:** capture status=0x21 (inexact+zero), then assert `clear_sticky` in the same cycle as a capture with status=0x02 → `sticky`=0x02 afterwards.
- **Reset mid-flight:** issue 3 ops, assert `rst` one cycle after the last issue → `out_valid`=0, `result_count`=0, `in_ready`=1; no capture occurs in the following LATENCY cycles.

Source files
------------

// File: rtl/fp_mult_result_collector.sv
// rtl/fp_mult_result_collector.sv - credit-tracked result FIFO with sticky flags behind the fixed-latency fp multiplier
module fp_mult_result_collector #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] z,
  input  logic [7:0]  status,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_z,
  output logic [7:0]  out_status,
  input  logic        clear_sticky,
  output logic [6:0]  sticky,
  output logic [15:0] result_count
);

  localparam int AW = $clog2(DEPTH);
  // Wide enough for DEPTH + LATENCY at the largest legal parameters.
  localparam int CW = 8;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [CW-1:0]      inflight_q, inflight_d;
  logic [CW-1:0]      occ_q, occ_d;
  logic [AW-1:0]      head_q, head_d;
  logic [AW-1:0]      tail_q, tail_d;
  logic [6:0]         sticky_q, sticky_d;
  logic [15:0]        count_q, count_d;
  logic [39:0]        mem_q [DEPTH];

  logic arrive;
  logic pop;
  logic full;
  logic drop;
  logic push;

  // A result is present on z/status exactly when its issue tag reaches the end of the pipe.
  assign arrive    = vld_pipe_q[LATENCY-1];
  assign out_valid = (occ_q != '0);
  assign pop       = out_valid & out_ready;
  assign full      = (occ_q == DEPTH_C);
  // A pop in the arrival cycle frees the slot, so only a full FIFO with no pop drops.
  assign drop      = arrive & full & ~pop;
  assign push      = arrive & ~drop;

  // Credit counts slots already promised to in-flight ops; registered state only.
  assign in_ready  = (occ_q + inflight_q) < DEPTH_C;

  assign out_z        = mem_q[head_q][39:8];
  assign out_status   = mem_q[head_q][7:0];
  assign sticky       = sticky_q;
  assign result_count = count_q;

  // Next-state for the issue-tag pipe, counters, pointers, flags.
  always_comb begin
    vld_pipe_d    = '0;
    vld_pipe_d[0] = in_valid;
    for (int i = 1; i < LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
    end

    inflight_d = inflight_q + CW'(in_valid) - CW'(arrive);
    occ_d      = occ_q + CW'(push) - CW'(pop);
    head_d     = head_q + AW'(pop);
    tail_d     = tail_q + AW'(push);
    count_d    = count_q + 16'(push);

    // Clear first, then accumulate, so a coincident capture or drop survives the clear.
    sticky_d = clear_sticky ? 7'd0 : sticky_q;
    if (push) begin
      sticky_d[5:0] = sticky_d[5:0] | status[5:0];
    end
    if (drop) begin
      sticky_d[6] = 1'b1;
    end
  end

  // Control state with synchronous reset; discards in-flight tags and FIFO contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      inflight_q <= '0;
      occ_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      sticky_q   <= '0;
      count_q    <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
    end
  end

  // Result storage; contents are only meaningful below occupancy so it needs no reset.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[tail_q] <= {z, status};
    end
  end

endmodule

// File: tb/tb_fp_mult_result_collector.sv
// tb/tb_fp_mult_result_collector.sv - directed self-checking bench for fp_mult_result_collector
module tb_fp_mult_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] z;
  logic [7:0]  status;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic [7:0]  out_status;
  logic        clear_sticky;
  logic [6:0]  sticky;
  logic [15:0] result_count;

  logic [31:0] iss_z, zp0, zp1;
  logic [7:0]  iss_st, sp0, sp1;

  int n_cmp = 0;
  int n_bad = 0;

  fp_mult_result_collector #(.LATENCY(2), .DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .z            (z),
    .status       (status),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_z        (out_z),
    .out_status   (out_status),
    .clear_sticky (clear_sticky),
    .sticky       (sticky),
    .result_count (result_count)
  );

  always #5 clk = ~clk;

  // Two-stage stand-in for the multiplier: values presented at issue appear two cycles later.
  always @(posedge clk) begin
    zp0 <= iss_z;
    zp1 <= zp0;
    sp0 <= iss_st;
    sp1 <= sp0;
  end
  assign z      = zp1;
  assign status = sp1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] zz, input logic [7:0] st);
    in_valid = 1'b1;
    iss_z    = zz;
    iss_st   = st;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    clear_sticky = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int nacc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clear_sticky = 1'b0;
    iss_z = '0; iss_st = '0;
    tick();

    // Single op
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_count", result_count, 0);
    check("rst_sticky", sticky, 0);
    issue(32'h4000_0000, 8'h00);
    tick();
    in_valid = 1'b0;
    tick();
    check("single_no_fallthru", out_valid, 0);
    tick();
    check("single_valid", out_valid, 1);
    check("single_z", out_z, 32'h4000_0000);
    check("single_count", result_count, 1);
    check("single_sticky", sticky, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_popped", out_valid, 0);

    // Fill with out_ready low, then overflow, then drain
    do_reset();
    nacc = 0;
    for (int c = 0; c < 12; c++) begin
      check("fill_in_ready", in_ready, 32'(c < 8));
      if (in_ready) begin
        issue(32'h100 + nacc, 8'h00);
        nacc++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    check("fill_accepted", nacc, 8);
    check("fill_count", result_count, 8);
    issue(32'h0000_DEAD, 8'h3F);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("ovf_sticky", sticky, 7'h40);
    check("ovf_count", result_count, 8);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) check("drain_in_ready_full", in_ready, 0);
      if (i == 1) check("drain_in_ready_back", in_ready, 1);
      check("drain_valid", out_valid, 1);
      check("drain_order", out_z, 32'h100 + i);
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", out_valid, 0);

    // Push and pop together at full
    do_reset();
    for (int c = 0; c < 9; c++) begin
      issue(32'h200 + c, 8'h00);
      tick();
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    check("fpp_head", out_z, 32'h200);
    tick();
    out_ready = 1'b0;
    check("fpp_sticky", sticky, 0);
    check("fpp_count", result_count, 9);
    out_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      check("fpp_valid", out_valid, 1);
      check("fpp_order", out_z, 32'h200 + i);
      tick();
    end
    out_ready = 1'b0;
    check("fpp_empty", out_valid, 0);

    // Sticky accumulate and clear-with-capture
    do_reset();
    issue(32'h1, 8'hE1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("sticky_first", sticky, 7'h21);
    check("sticky_raw_status", out_status, 8'hE1);
    issue(32'h2, 8'h02);
    tick();
    in_valid = 1'b0;
    tick();
    clear_sticky = 1'b1;
    tick();
    clear_sticky = 1'b0;
    check("sticky_clear_capture", sticky, 7'h02);
    check("sticky_count", result_count, 2);
    clear_sticky = 1'b1;
    tick();
    clear_sticky = 1'b0;
    check("sticky_clear_only", sticky, 0);

    // Reset mid-flight
    do_reset();
    for (int c = 0; c < 3; c++) begin
      issue(32'h11 + c, 8'h20);
      tick();
    end
    in_valid = 1'b0;
    check("mid_pre_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_out_valid", out_valid, 0);
    check("mid_count", result_count, 0);
    check("mid_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) tick();
    check("mid_no_capture_valid", out_valid, 0);
    check("mid_no_capture_count", result_count, 0);
    check("mid_no_capture_sticky", sticky, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
